seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised time-multiplexed scan sequencer for common-anode 7-segment displays, generalising the fixed 4-digit, 16-state digit driver.
- Steps through `NUM_DIGITS` digit slots. Each slot has an address-setup blanking phase, a brightness-controlled lit window and a trailing guard blanking phase.
- Drives active-low anodes plus the relative digit address used by the segment-data mux.
- Sits between the display data registers and the top-level pins.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digits; must be ≥ 2.
- `ADDR_W`, default `$clog2(NUM_DIGITS)`: width of `digit_addr`.
- `SLOT_TICKS`, default 4: ticks per digit slot; must be ≥ 3.
- `PRESCALE`, default 1: clk cycles per tick; must be ≥ 1.
- `DUTY_W`, default 3: width of `brightness`.

Ports:
- `clk`  in  1: clock clk.
- `reset`  in  1: reset reset, asynchronous, active-high.
- `enable`  in  1: run scan; low blanks the display and parks the sequencer.
- `digit_mask`  in  NUM_DIGITS: bit k=1 allows digit_addr k to light.
- `brightness`  in  DUTY_W: requested lit ticks per slot.
- `digit_addr`  out  ADDR_W: relative address of the digit whose slot is active.
- `anodes`  out  NUM_DIGITS: active-low; digit_addr k drives bit NUM_DIGITS-1-k.
- `frame_start`  out  1: one-clk pulse when the sequencer enters digit 0, phase 0.

## Operation
- State consists of the prescaler count, `phase` (0..SLOT_TICKS-1) and `digit` (0..NUM_DIGITS-1). `phase` and `digit` advance only on a tick.
- Tick: asserted when the prescaler count equals PRESCALE-1; the count then wraps to 0. With PRESCALE=1, every cycle is a tick.
- Phase 0 (setup):
  - `digit_addr`=digit, all anodes high.
  - `brightness` is latched into `lvl` here; changes mid-slot do not take effect until the next slot.
- Lit phases are 1..L, where L = min(lvl, SLOT_TICKS-2).
  - During a lit phase, the anode bit for `digit` is 0 if `digit_mask[digit]`=1.
  - All other anode bits are 1.
- Phases L+1..SLOT_TICKS-1 are blank guard phases; `digit_addr` is held.
- End of slot: phase SLOT_TICKS-1 followed by a tick goes to phase 0 of digit+1. digit NUM_DIGITS-1 wraps to 0.
- A masked digit or L=0 still consumes its full slot, so frame time is constant.
- At most one anode is low at any time. An anode is never low in the same cycle `digit_addr` changes.
- `enable` low:
  - Synchronously clears the prescaler, digit and phase counters.
  - Forces anodes to all 1s, `digit_addr` to 0 and `frame_start` to 0.
- `enable` rising: the first tick enters digit 0 at phase 1 (phase 0 is already occupied while parked).

## Timing
- All outputs are registered and computed from the next-state values, so they change on the tick edge with zero extra latency.
- Reset values: `anodes`=all 1s, `digit_addr`=0, `frame_start`=0, counters=0, `lvl`=0.
- Reset mid-frame blanks the display immediately (asynchronously). Restart is at digit 0, phase 0, with no `frame_start` pulse for that restart.
- `frame_start` rises in the cycle the sequencer wraps from digit NUM_DIGITS-1 into digit 0, phase 0. It lasts one clk, independent of PRESCALE.
- Frame length = NUM_DIGITS·SLOT_TICKS·PRESCALE clk.
- Duty per digit = L/(NUM_DIGITS·SLOT_TICKS).
- Width rules:
  - Comparison L ≤ SLOT_TICKS-2 is evaluated at width max(DUTY_W, $clog2(SLOT_TICKS)+1).
  - No truncation of `brightness`.

## Structure
- Package `seg_scan_pkg`: `ANODE_OFF` (all-ones helper function) and parameter legality checks (elaboration-time assertions on NUM_DIGITS, SLOT_TICKS, PRESCALE).
- Sub-module `scan_prescaler`:
  - Parameterised by PRESCALE; inputs `clk`, `reset`, synchronous `clear`; output `tick`.
  - At PRESCALE=1 it ties `tick` to 1.
- The phase/digit counters and output decode stay in `seg_scan_driver`.

## Test plan
- Defaults, brightness=7, mask=4'b1111: per slot, anodes are 1111, then 0111 for 2 clk, then 1111. Digit 0 lights 0111, digit 1 lights 1011, digit 2 lights 1101, digit 3 lights 1110. `digit_addr` sequence is 0,1,2,3, each held 4 clk. `frame_start` pulses every 16 clk.
- brightness=1, then 0: 1 lit clk per slot, then none. Change brightness mid-slot: the new value first applies in the next slot.
- mask=4'b0101 (digits 0 and 2 enabled): digits 1 and 3 never go low. Frame stays 16 clk.
- PRESCALE=3, NUM_DIGITS=6, SLOT_TICKS=5, brightness=3: lit window is 9 clk per slot. Frame is 90 clk. At most one anode is ever low.
- Assert reset mid-lit-phase: anodes go to all 1s asynchronously. After release, restart at addr 0, phase 0, with no `frame_start` pulse.
- Drop enable for 5 clk mid-frame: all blank, `digit_addr`=0. On re-enable, digit 0 is lit on the first tick.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared helpers for the 7-segment scan sequencer: the anode-off pattern
// and the parameter legality check.
package seg_scan_pkg;

   localparam int MAX_DIGITS = 32;

   // The caller takes the low n bits. This gives an all-ones blanking pattern for any digit count.
   function automatic logic [MAX_DIGITS-1:0] ANODE_OFF(input int n);
      logic [MAX_DIGITS-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < n) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic bit params_ok(input int num_digits, input int slot_ticks,
                                    input int prescale);
      return (num_digits >= 2) && (num_digits <= MAX_DIGITS) &&
             (slot_ticks >= 3) && (prescale >= 1);
   endfunction

endpackage

// File: rtl/seg_scan_driver_prescaler.sv
// Tick generator: one-cycle tick every PRESCALE clocks, restartable via clear.
module scan_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   generate
      if (PRESCALE == 1) begin : g_bypass
         logic unused_inputs;
         assign unused_inputs = clk ^ reset ^ clear;
         assign tick = 1'b1;
      end else begin : g_count
         localparam int CW = $clog2(PRESCALE);
         localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
         logic [CW-1:0] count;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               count <= '0;
            end else if (clear || count == LAST) begin
               count <= '0;
            end else begin
               count <= count + 1'b1;
            end
         end

         assign tick = (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode digit scanner: per slot a setup blank, a
// brightness-sized lit window and a guard blank, outputs registered.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int ADDR_W     = $clog2(NUM_DIGITS),
   parameter int SLOT_TICKS = 4,
   parameter int PRESCALE   = 1,
   parameter int DUTY_W     = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NUM_DIGITS-1:0] digit_mask,
   input  logic [DUTY_W-1:0]     brightness,
   output logic [ADDR_W-1:0]     digit_addr,
   output logic [NUM_DIGITS-1:0] anodes,
   output logic                  frame_start
);

   localparam int PW = $clog2(SLOT_TICKS);
   localparam int CW = (DUTY_W > PW + 1) ? DUTY_W : PW + 1;
   localparam logic [PW-1:0]     PH_LAST = PW'(SLOT_TICKS - 1);
   localparam logic [ADDR_W-1:0] DG_LAST = ADDR_W'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]     L_MAX   = CW'(SLOT_TICKS - 2);
   localparam logic [MAX_DIGITS-1:0] OFF_WIDE = ANODE_OFF(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] OFF     = OFF_WIDE[NUM_DIGITS-1:0];
   localparam logic [NUM_DIGITS-1:0] TOP_BIT = {1'b1, {(NUM_DIGITS-1){1'b0}}};

   generate
      if (!params_ok(NUM_DIGITS, SLOT_TICKS, PRESCALE) || ADDR_W < $clog2(NUM_DIGITS))
      begin : g_param_error
         $error("seg_scan_driver: illegal parameter combination");
      end
   endgenerate

   logic                  tick;
   logic [PW-1:0]         phase, phase_n;
   logic [ADDR_W-1:0]     digit, digit_n;
   logic [DUTY_W-1:0]     lvl, lvl_n;
   logic [CW-1:0]         phase_ext, lvl_ext;
   logic                  lit;
   logic [NUM_DIGITS-1:0] anodes_n;
   logic                  frame_n;

   scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (!enable),
      .tick  (tick)
   );

   always_comb begin
      phase_n = phase;
      digit_n = digit;
      if (!enable) begin
         phase_n = '0;
         digit_n = '0;
      end else if (tick) begin
         if (phase == PH_LAST) begin
            phase_n = '0;
            digit_n = (digit == DG_LAST) ? '0 : digit + 1'b1;
         end else begin
            phase_n = phase + 1'b1;
         end
      end

      // Brightness is sampled for as long as the slot sits in setup.
      // The value present on the tick that leaves setup sizes the whole window.
      lvl_n     = (phase == '0) ? brightness : lvl;
      phase_ext = CW'(phase_n);
      lvl_ext   = CW'(lvl_n);
      lit       = enable && (phase_n != '0) && (phase_ext <= lvl_ext) &&
                  (phase_ext <= L_MAX) && digit_mask[digit_n];
      anodes_n  = lit ? ~(TOP_BIT >> digit_n) : OFF;
      frame_n   = enable && tick && (phase == PH_LAST) && (digit == DG_LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase       <= '0;
         digit       <= '0;
         lvl         <= '0;
         anodes      <= OFF;
         frame_start <= 1'b0;
      end else begin
         phase       <= phase_n;
         digit       <= digit_n;
         lvl         <= lvl_n;
         anodes      <= anodes_n;
         frame_start <= frame_n;
      end
   end

   assign digit_addr = digit;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a default 4-digit instance and a 6-digit,
// 5-tick, prescale-3 instance, both checked against a position-based model.
module tb_seg_scan_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, enable;
   logic [3:0] mask4;
   logic [2:0] bright4;
   logic [5:0] mask6;
   logic [2:0] bright6;
   logic [1:0] addr4;
   logic [3:0] an4;
   logic       fs4;
   logic [2:0] addr6;
   logic [5:0] an6;
   logic       fs6;

   int asserts = 0;
   int failures = 0;

   // Model state: clk edges with enable high since the last park/reset,
   // and the brightness latched for the current slot.
   int c4 = 0, lvl4 = 0, c6 = 0, lvl6 = 0;
   logic [7:0] e_an4, e_addr4, e_an6, e_addr6;
   logic       e_fs4, e_fs6;

   seg_scan_driver dut4 (
      .clk(clk), .reset(reset), .enable(enable), .digit_mask(mask4),
      .brightness(bright4), .digit_addr(addr4), .anodes(an4), .frame_start(fs4)
   );

   seg_scan_driver #(.NUM_DIGITS(6), .SLOT_TICKS(5), .PRESCALE(3), .DUTY_W(3)) dut6 (
      .clk(clk), .reset(reset), .enable(enable), .digit_mask(mask6),
      .brightness(bright6), .digit_addr(addr6), .anodes(an6), .frame_start(fs6)
   );

   function automatic void model_out(input int c, input int p, input int nd, input int st,
                                     input int lvl, input logic [7:0] mask,
                                     output logic [7:0] an, output logic [7:0] addr,
                                     output logic fs);
      int s, d, ph, l;
      s  = (c / p) % (nd * st);
      d  = s / st;
      ph = s % st;
      l  = (lvl < st - 2) ? lvl : st - 2;
      an = 8'hFF;
      if (ph >= 1 && ph <= l && mask[d]) an[nd-1-d] = 1'b0;
      addr = 8'(d);
      fs   = (c > 0) && (c % p == 0) && (s == 0);
   endfunction

   task automatic advance();
      @(posedge clk);
      if (reset || !enable) begin
         c4 = 0;
         c6 = 0;
      end else begin
         c4++;
         if ((c4 % 16) % 4 == 1) lvl4 = int'(bright4);
         c6++;
         if (c6 % 3 == 0 && ((c6 / 3) % 30) % 5 == 1) lvl6 = int'(bright6);
      end
      model_out(c4, 1, 4, 4, lvl4, {4'b0, mask4}, e_an4, e_addr4, e_fs4);
      model_out(c6, 3, 6, 5, lvl6, {2'b0, mask6}, e_an6, e_addr6, e_fs6);
      #1;
   endtask

   task automatic align4();
      for (int i = 0; i < 32 && (c4 % 16) != 0; i++) advance();
   endtask

   task automatic test_reset();
      #2;
      asserts++; if (an4 !== 4'hF) begin failures++; $display("FAIL reset_an4 got %b exp 1111", an4); end
      asserts++; if (addr4 !== 2'd0) begin failures++; $display("FAIL reset_addr4 got %0d exp 0", addr4); end
      asserts++; if (fs4 !== 1'b0) begin failures++; $display("FAIL reset_fs4 got %b exp 0", fs4); end
      asserts++; if (an6 !== 6'h3F) begin failures++; $display("FAIL reset_an6 got %b exp 111111", an6); end
      asserts++; if (addr6 !== 3'd0) begin failures++; $display("FAIL reset_addr6 got %0d exp 0", addr6); end
      advance();
      advance();
      asserts++; if (an4 !== 4'hF || fs4 !== 1'b0) begin failures++; $display("FAIL reset_hold got an=%b fs=%b exp 1111/0", an4, fs4); end
      reset = 1'b0;
   endtask

   task automatic test_full_brightness();
      int n0111 = 0, nfs = 0;
      for (int i = 0; i < 48; i++) begin
         advance();
         asserts++; if (an4 !== e_an4[3:0]) begin failures++; $display("FAIL full_an4 c=%0d got %b exp %b", c4, an4, e_an4[3:0]); end
         asserts++; if (addr4 !== e_addr4[1:0]) begin failures++; $display("FAIL full_addr4 c=%0d got %0d exp %0d", c4, addr4, e_addr4); end
         asserts++; if (fs4 !== e_fs4) begin failures++; $display("FAIL full_fs4 c=%0d got %b exp %b", c4, fs4, e_fs4); end
         if (an4 == 4'b0111) n0111++;
         if (fs4) nfs++;
      end
      asserts++; if (n0111 != 6) begin failures++; $display("FAIL full_lit_count got %0d exp 6", n0111); end
      asserts++; if (nfs != 3) begin failures++; $display("FAIL full_frame_count got %0d exp 3", nfs); end
   endtask

   task automatic test_brightness();
      int lit;
      align4();
      bright4 = 3'd1;
      lit = 0;
      for (int i = 0; i < 32; i++) begin
         advance();
         asserts++; if (an4 !== e_an4[3:0]) begin failures++; $display("FAIL b1_an4 c=%0d got %b exp %b", c4, an4, e_an4[3:0]); end
         if (an4 != 4'hF) lit++;
      end
      asserts++; if (lit != 8) begin failures++; $display("FAIL b1_lit_count got %0d exp 8", lit); end
      bright4 = 3'd0;
      lit = 0;
      for (int i = 0; i < 32; i++) begin
         advance();
         if (an4 != 4'hF) lit++;
      end
      asserts++; if (lit != 0) begin failures++; $display("FAIL b0_lit_count got %0d exp 0", lit); end
      align4();
      bright4 = 3'd1;
      advance();
      asserts++; if (an4 !== 4'b0111) begin failures++; $display("FAIL mid_first got %b exp 0111", an4); end
      bright4 = 3'd7;
      advance();
      asserts++; if (an4 !== 4'hF) begin failures++; $display("FAIL mid_no_effect got %b exp 1111", an4); end
      advance();
      advance();
      advance();
      asserts++; if (an4 !== 4'b1011) begin failures++; $display("FAIL mid_next_slot1 got %b exp 1011", an4); end
      advance();
      asserts++; if (an4 !== 4'b1011) begin failures++; $display("FAIL mid_next_slot2 got %b exp 1011", an4); end
      for (int i = 0; i < 64; i++) begin
         bright4 = 3'($urandom_range(0, 7));
         advance();
         asserts++; if (an4 !== e_an4[3:0]) begin failures++; $display("FAIL rbright_an4 c=%0d got %b exp %b", c4, an4, e_an4[3:0]); end
      end
      bright4 = 3'd7;
   endtask

   task automatic test_mask();
      int viol = 0, nfs = 0;
      align4();
      mask4 = 4'b0101;
      for (int i = 0; i < 32; i++) begin
         advance();
         asserts++; if (an4 !== e_an4[3:0]) begin failures++; $display("FAIL mask_an4 c=%0d got %b exp %b", c4, an4, e_an4[3:0]); end
         if (an4[2] == 1'b0 || an4[0] == 1'b0) viol++;
         if (fs4) nfs++;
      end
      asserts++; if (viol != 0) begin failures++; $display("FAIL mask_masked_lit got %0d exp 0", viol); end
      asserts++; if (nfs != 2) begin failures++; $display("FAIL mask_frames got %0d exp 2", nfs); end
      mask4 = 4'hF;
   endtask

   task automatic test_wide_config();
      int nd0 = 0, nfs = 0;
      for (int i = 0; i < 100 && (c6 % 90) != 0; i++) advance();
      for (int i = 0; i < 180; i++) begin
         advance();
         asserts++; if (an6 !== e_an6[5:0]) begin failures++; $display("FAIL wide_an6 c=%0d got %b exp %b", c6, an6, e_an6[5:0]); end
         asserts++; if (addr6 !== e_addr6[2:0]) begin failures++; $display("FAIL wide_addr6 c=%0d got %0d exp %0d", c6, addr6, e_addr6); end
         asserts++; if (fs6 !== e_fs6) begin failures++; $display("FAIL wide_fs6 c=%0d got %b exp %b", c6, fs6, e_fs6); end
         asserts++; if ($countones(~an6) > 1) begin failures++; $display("FAIL wide_onehot got %b exp at most one low", an6); end
         if (an6 == 6'b011111) nd0++;
         if (fs6) nfs++;
      end
      asserts++; if (nd0 != 18) begin failures++; $display("FAIL wide_lit_count got %0d exp 18", nd0); end
      asserts++; if (nfs != 2) begin failures++; $display("FAIL wide_frames got %0d exp 2", nfs); end
   endtask

   task automatic test_reset_mid_lit();
      int nfs = 0;
      align4();
      advance();
      asserts++; if (an4 !== 4'b0111) begin failures++; $display("FAIL rst_lit_before got %b exp 0111", an4); end
      #2 reset = 1'b1;
      #1;
      asserts++; if (an4 !== 4'hF) begin failures++; $display("FAIL rst_async_an4 got %b exp 1111", an4); end
      asserts++; if (addr4 !== 2'd0) begin failures++; $display("FAIL rst_async_addr4 got %0d exp 0", addr4); end
      asserts++; if (an6 !== 6'h3F) begin failures++; $display("FAIL rst_async_an6 got %b exp 111111", an6); end
      advance();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         advance();
         asserts++; if (an4 !== e_an4[3:0] || addr4 !== e_addr4[1:0]) begin failures++; $display("FAIL rst_restart c=%0d got %b/%0d exp %b/%0d", c4, an4, addr4, e_an4[3:0], e_addr4); end
         if (fs4) nfs++;
      end
      asserts++; if (nfs != 0) begin failures++; $display("FAIL rst_no_pulse got %0d exp 0", nfs); end
      advance();
      asserts++; if (fs4 !== 1'b1) begin failures++; $display("FAIL rst_first_frame got %b exp 1", fs4); end
   endtask

   task automatic test_enable_drop();
      align4();
      for (int i = 0; i < 7; i++) advance();
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         advance();
         asserts++; if (an4 !== 4'hF || addr4 !== 2'd0 || fs4 !== 1'b0) begin failures++; $display("FAIL en_parked got %b/%0d/%b exp 1111/0/0", an4, addr4, fs4); end
      end
      enable = 1'b1;
      advance();
      asserts++; if (an4 !== 4'b0111 || addr4 !== 2'd0) begin failures++; $display("FAIL en_first_tick got %b/%0d exp 0111/0", an4, addr4); end
      for (int i = 0; i < 20; i++) begin
         advance();
         asserts++; if (an4 !== e_an4[3:0] || fs4 !== e_fs4) begin failures++; $display("FAIL en_resume c=%0d got %b/%b exp %b/%b", c4, an4, fs4, e_an4[3:0], e_fs4); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bright4 = 3'($urandom_range(0, 7));
         bright6 = 3'($urandom_range(0, 7));
         mask4   = 4'($urandom);
         mask6   = 6'($urandom);
         enable  = ($urandom_range(0, 19) != 0);
         advance();
         asserts++; if (an4 !== e_an4[3:0]) begin failures++; $display("FAIL rnd_an4 c=%0d got %b exp %b", c4, an4, e_an4[3:0]); end
         asserts++; if (addr4 !== e_addr4[1:0] || fs4 !== e_fs4) begin failures++; $display("FAIL rnd_addr_fs4 c=%0d got %0d/%b exp %0d/%b", c4, addr4, fs4, e_addr4, e_fs4); end
         asserts++; if (an6 !== e_an6[5:0]) begin failures++; $display("FAIL rnd_an6 c=%0d got %b exp %b", c6, an6, e_an6[5:0]); end
         asserts++; if (addr6 !== e_addr6[2:0] || fs6 !== e_fs6) begin failures++; $display("FAIL rnd_addr_fs6 c=%0d got %0d/%b exp %0d/%b", c6, addr6, fs6, e_addr6, e_fs6); end
         asserts++; if ($countones(~an4) > 1 || $countones(~an6) > 1) begin failures++; $display("FAIL rnd_onehot got %b/%b exp at most one low", an4, an6); end
      end
      enable = 1'b1;
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b1;
      bright4 = 3'd7;
      mask4   = 4'hF;
      bright6 = 3'd3;
      mask6   = 6'h3F;
      test_reset();
      test_full_brightness();
      test_brightness();
      test_mask();
      test_wide_config();
      test_reset_mid_lit();
      test_enable_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
